// File: rtl/jtframe_pocket_upload.sv
// Bridge read server for the Pocket: fetches four bytes from core memory
// over the ioctl upload bus and returns them as one little-endian 32-bit word.
// A one-word sequential prefetch hides fetch latency for linear read streams.
//
// Ports:
//   clk_rom, rst          clock, asynchronous active-high reset
//   rd_req, rd_addr       single-cycle bridge read request and word address
//   rd_data, rd_ack       returned word, single-cycle acknowledge
//   ds_done               dataslot complete level; rising edge ends the session
//   ioctl_addr, ioctl_din byte address to core memory, byte read back
//   ioctl_ram, uploading  upload session in progress
//   req_ovf               sticky: a request was dropped
module jtframe_pocket_upload #(
  parameter logic [7:0]  REGION   = 8'hF8,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned PREFETCH = 1
) (
  input  logic        clk_rom,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_ack,
  input  logic        ds_done,
  output logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_din,
  output logic        ioctl_ram,
  output logic        uploading,
  output logic        req_ovf
);

  localparam int unsigned AW = 25;
  localparam int unsigned TW = 5;

  typedef enum logic [1:0] {IDLE, FETCH, RESP, PREF} state_t;

  state_t state_q, state_d;

  logic [31:0]   cur_addr_q;
  logic [31:0]   pf_addr_q;
  logic [31:0]   pf_word_q;
  logic          pf_valid_q;
  logic          pend_valid_q;
  logic [31:0]   pend_addr_q;
  logic [TW-1:0] t_q;
  logic [1:0]    ka_q;
  logic [1:0]    s_q;
  logic [23:0]   word_q;
  logic          ds_q;

  logic [31:0] req_a;
  logic [31:0] next_addr;
  logic        serve, do_oow, do_hit, do_miss, do_pref, pf_ack, pf_fill, pf_kill;
  logic        pend_set, pend_clr, ovf_set;
  logic        busy, samp, last, adv, ds_rise;

  // Cycle (from byte-sequence start) at which byte k has been valid for RD_LAT
  function automatic logic [TW-1:0] mark(input logic [1:0] k);
    return TW'(RD_LAT) * (TW'(k) + TW'(1));
  endfunction

  function automatic logic in_win(input logic [7:0] hi);
    return hi == REGION;
  endfunction

  function automatic logic [AW-1:0] base_of(input logic [22:0] a);
    return {a, 2'b00};
  endfunction

  assign next_addr = cur_addr_q + 32'd1;
  assign ds_rise   = ds_done & ~ds_q;
  assign busy      = (state_q == FETCH) || (state_q == PREF);
  // Byte s is sampled RD_LAT cycles after its address went out
  assign samp      = busy && (t_q == mark(s_q));
  assign last      = samp && (s_q == 2'd3);
  // Next byte address goes out as the previous one completes its latency
  assign adv       = busy && (ka_q != 2'd3) && (t_q == mark(ka_q) - TW'(1));

  // State register
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and action decode
  always_comb begin
    state_d  = state_q;
    req_a    = rd_addr;
    serve    = 1'b0;
    do_oow   = 1'b0;
    do_hit   = 1'b0;
    do_miss  = 1'b0;
    do_pref  = 1'b0;
    pf_ack   = 1'b0;
    pf_fill  = 1'b0;
    pf_kill  = ds_rise;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    ovf_set  = 1'b0;
    case (state_q)
      IDLE: begin
        // A pending request is served first; a new one refills the slot
        if (pend_valid_q) begin
          serve    = 1'b1;
          req_a    = pend_addr_q;
          pend_clr = 1'b1;
          pend_set = rd_req;
        end else begin
          serve = rd_req;
        end
      end
      FETCH: begin
        if (rd_req) begin
          if (pend_valid_q) ovf_set = 1'b1;
          else              pend_set = 1'b1;
        end
        if (last) state_d = RESP;
      end
      RESP: begin
        if (rd_req) begin
          if (pend_valid_q) ovf_set = 1'b1;
          else              pend_set = 1'b1;
        end
        if ((PREFETCH != 0) && !ds_done && !pend_valid_q && !rd_req &&
            in_win(next_addr[31:24])) begin
          do_pref = 1'b1;
          state_d = PREF;
        end else begin
          state_d = IDLE;
        end
      end
      PREF: begin
        if (ds_rise) begin
          state_d = IDLE;
          if (rd_req) begin
            if (pend_valid_q) ovf_set = 1'b1;
            else              pend_set = 1'b1;
          end
        end else if (rd_req && !pend_valid_q && (rd_addr != pf_addr_q)) begin
          // Different address: drop the prefetch and serve the request now
          pf_kill = 1'b1;
          serve   = 1'b1;
        end else begin
          if (rd_req) begin
            if (pend_valid_q) ovf_set = 1'b1;
            else              pend_set = 1'b1;
          end
          if (last) begin
            pf_fill = 1'b1;
            if (pend_valid_q) begin
              pend_clr = 1'b1;
              pf_ack   = 1'b1;
              state_d  = RESP;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (serve) begin
      if (!in_win(req_a[31:24])) begin
        do_oow  = 1'b1;
        state_d = IDLE;
      end else if (pf_valid_q && !pf_kill && (req_a == pf_addr_q)) begin
        do_hit  = 1'b1;
        state_d = RESP;
      end else begin
        do_miss = 1'b1;
        state_d = FETCH;
      end
    end
  end

  // Datapath, byte sequencer and registered outputs
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      rd_data      <= '0;
      rd_ack       <= 1'b0;
      ioctl_addr   <= '0;
      ioctl_ram    <= 1'b0;
      uploading    <= 1'b0;
      req_ovf      <= 1'b0;
      cur_addr_q   <= '0;
      pf_addr_q    <= '0;
      pf_word_q    <= '0;
      pf_valid_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      t_q          <= '0;
      ka_q         <= '0;
      s_q          <= '0;
      word_q       <= '0;
      ds_q         <= 1'b0;
    end else begin
      ds_q   <= ds_done;
      rd_ack <= 1'b0;

      if (pend_clr) pend_valid_q <= 1'b0;
      if (pend_set) begin
        pend_valid_q <= 1'b1;
        pend_addr_q  <= rd_addr;
      end
      if (ovf_set) req_ovf <= 1'b1;

      if (busy) begin
        t_q <= t_q + TW'(1);
        if (adv) begin
          ioctl_addr <= ioctl_addr + AW'(1);
          ka_q       <= ka_q + 2'd1;
        end
        if (samp) begin
          s_q <= s_q + 2'd1;
          case (s_q)
            2'd0:    word_q[7:0]   <= ioctl_din;
            2'd1:    word_q[15:8]  <= ioctl_din;
            2'd2:    word_q[23:16] <= ioctl_din;
            default: ;
          endcase
        end
      end

      if (do_miss) begin
        ioctl_addr <= base_of(req_a[22:0]);
        cur_addr_q <= req_a;
        t_q        <= '0;
        ka_q       <= '0;
        s_q        <= '0;
      end
      if (do_pref) begin
        ioctl_addr <= base_of(next_addr[22:0]);
        pf_addr_q  <= next_addr;
        pf_valid_q <= 1'b0;
        t_q        <= '0;
        ka_q       <= '0;
        s_q        <= '0;
      end
      if (do_hit) cur_addr_q <= req_a;
      if (pf_ack) cur_addr_q <= pf_addr_q;

      if (pf_fill) begin
        pf_word_q  <= {ioctl_din, word_q};
        pf_valid_q <= 1'b1;
      end
      if (pf_kill) pf_valid_q <= 1'b0;

      // A miss re-opens the session even when ds_done rises in the same cycle
      if (do_miss) begin
        uploading <= 1'b1;
        ioctl_ram <= 1'b1;
      end else if (ds_rise) begin
        uploading <= 1'b0;
        ioctl_ram <= 1'b0;
      end

      if (do_oow) begin
        rd_ack  <= 1'b1;
        rd_data <= '0;
      end
      if (do_hit) begin
        rd_ack  <= 1'b1;
        rd_data <= pf_word_q;
      end
      if (((state_q == FETCH) && last) || pf_ack) begin
        rd_ack  <= 1'b1;
        rd_data <= {ioctl_din, word_q};
      end
    end
  end

endmodule

// File: tb/tb_jtframe_pocket_upload.sv
// Self-checking bench for jtframe_pocket_upload with RD_LAT=2 and a
// byte-addressed memory model behind a two-cycle read pipeline.
module tb_jtframe_pocket_upload;

  localparam int unsigned LAT = 2;

  logic        clk_rom = 1'b0;
  logic        rst;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_ack;
  logic        ds_done;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_ram;
  logic        uploading;
  logic        req_ovf;

  jtframe_pocket_upload #(
    .REGION   (8'hF8),
    .RD_LAT   (LAT),
    .PREFETCH (1)
  ) dut (
    .clk_rom    (clk_rom),
    .rst        (rst),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_ack     (rd_ack),
    .ds_done    (ds_done),
    .ioctl_addr (ioctl_addr),
    .ioctl_din  (ioctl_din),
    .ioctl_ram  (ioctl_ram),
    .uploading  (uploading),
    .req_ovf    (req_ovf)
  );

  always #5 clk_rom = ~clk_rom;

  // Core memory: din in cycle n reflects the address of cycle n-2
  logic [7:0]  mem [256];
  logic [24:0] a1, a2;
  always @(posedge clk_rom) begin
    a1 <= ioctl_addr;
    a2 <= a1;
  end
  assign ioctl_din = mem[a2[7:0]];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  always @(posedge clk_rom) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
  endtask

  // Expected word for a bridge read, from the address rules alone
  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [31:0] w;
    logic [24:0] base;
    w = '0;
    if (a[31:24] == 8'hF8) begin
      base = {a[22:0], 2'b00};
      for (int k = 0; k < 4; k++) w[8*k +: 8] = mem[8'(base + 25'(k))];
    end
    return w;
  endfunction

  // Scoreboard: every ack must deliver the next expected word in order,
  // and rd_data must hold between acks
  logic [31:0] exp_q [$];
  logic [31:0] last_data = '0;
  int          ack_cnt = 0;
  int          ack_cyc = 0;
  always @(negedge clk_rom) begin
    if (rst) begin
      last_data = '0;
    end else if (rd_ack) begin
      ack_cnt++;
      ack_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_ack: rd_ack=1 data 0x%08h, required no ack", rd_data);
      end else begin
        check("ack_data", rd_data, exp_q.pop_front());
      end
      last_data = rd_data;
    end else begin
      check("rd_data_hold", rd_data, last_data);
    end
  end

  task automatic issue(input logic [31:0] a, output int rc);
    @(posedge clk_rom); #1;
    rd_req  = 1'b1;
    rd_addr = a;
    rc      = cyc;
    exp_q.push_back(model_word(a));
    @(posedge clk_rom); #1;
    rd_req = 1'b0;
  endtask

  task automatic wait_ack(input int target, input int bound, input string name);
    int n = 0;
    while (ack_cnt < target && n < bound) begin
      @(negedge clk_rom); #1;
      n++;
    end
    if (ack_cnt < target) begin
      checks++;
      $display("FAIL %s: acks %0d after %0d cycles, required %0d", name, ack_cnt, n, target);
    end
  endtask

  task automatic wait_addr(input logic [24:0] a, input int bound, input string name);
    int n = 0;
    while (ioctl_addr !== a && n < bound) begin
      @(posedge clk_rom); #1;
      n++;
    end
    check(name, 32'(ioctl_addr), 32'(a));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rc;
    int na = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[8'h40] = 8'h11;
    mem[8'h41] = 8'h22;
    mem[8'h42] = 8'h33;
    mem[8'h43] = 8'h44;
    rst = 1'b1; rd_req = 1'b0; rd_addr = '0; ds_done = 1'b0;
    repeat (3) @(posedge clk_rom); #1;
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_ioctl_addr", 32'(ioctl_addr), 32'h0);
    check("reset_flags", 32'({rd_ack, ioctl_ram, uploading, req_ovf}), 32'h0);
    rst = 1'b0;
    @(posedge clk_rom); #1;

    // 1: cold miss
    issue(32'hF800_0010, rc); na++;
    check("t1_uploading", 32'(uploading), 32'h1);
    check("t1_ioctl_ram", 32'(ioctl_ram), 32'h1);
    check("t1_addr0", 32'(ioctl_addr), 32'h40);
    for (int k = 1; k < 4; k++) begin
      repeat (LAT) @(posedge clk_rom); #1;
      check("t1_addr_step", 32'(ioctl_addr), 32'h40 + 32'(k));
    end
    wait_ack(na, 20, "t1_ack");
    check("t1_latency", 32'(ack_cyc - rc), 32'd10);
    check("t1_data", rd_data, 32'h4433_2211);
    repeat (15) @(posedge clk_rom);

    // 2: prefetch hit, then next prefetch
    issue(32'hF800_0011, rc); na++;
    wait_ack(na, 5, "t2_ack");
    check("t2_latency", 32'(ack_cyc - rc), 32'd1);
    check("t2_data", rd_data, 32'hE2E3_E0E1);
    wait_addr(25'h48, 10, "t2_pref_first");
    wait_addr(25'h4B, 12, "t2_pref_last");
    repeat (10) @(posedge clk_rom);

    // 3: out of window
    issue(32'h1000_0000, rc); na++;
    wait_ack(na, 5, "t3_ack");
    check("t3_latency", 32'(ack_cyc - rc), 32'd1);
    check("t3_data", rd_data, 32'h0);
    check("t3_ioctl_addr", 32'(ioctl_addr), 32'h4B);
    check("t3_uploading", 32'(uploading), 32'h1);

    // 4: pending slot and overflow
    exp_q.push_back(model_word(32'hF800_0020));
    exp_q.push_back(model_word(32'hF800_0030));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_rom); #1;
      rd_req  = (c == 0) || (c == 3) || (c == 4);
      rd_addr = (c == 0) ? 32'hF800_0020 : (c == 3) ? 32'hF800_0030 : 32'hF800_0040;
      if (c == 0) rc = cyc;
    end
    @(posedge clk_rom); #1;
    rd_req = 1'b0;
    na += 2;
    wait_ack(na - 1, 20, "t4_ack1");
    check("t4_latency", 32'(ack_cyc - rc), 32'd10);
    check("t4_data1", rd_data, 32'h2627_2425);
    wait_ack(na, 30, "t4_ack2");
    check("t4_data2", rd_data, 32'h6667_6465);
    check("t4_req_ovf", 32'(req_ovf), 32'h1);

    // Request matching the running prefetch is held until it completes
    issue(32'hF800_0031, rc); na++;
    wait_ack(na, 20, "hold_ack");
    check("hold_latency", 32'(ack_cyc - rc), 32'd9);
    // A different address aborts the prefetch and takes a full miss
    issue(32'hF800_0070, rc); na++;
    wait_ack(na, 20, "abort_ack");
    check("abort_latency", 32'(ack_cyc - rc), 32'd10);
    repeat (15) @(posedge clk_rom);

    // 5: ds_done mid-fetch
    issue(32'hF800_0050, rc); na++;
    repeat (3) @(posedge clk_rom); #1;
    ds_done = 1'b1;
    @(posedge clk_rom); #1;
    check("t5_uploading", 32'(uploading), 32'h0);
    check("t5_ioctl_ram", 32'(ioctl_ram), 32'h0);
    wait_ack(na, 20, "t5_ack");
    check("t5_latency", 32'(ack_cyc - rc), 32'd10);
    check("t5_data", rd_data, 32'h4433_2211);
    repeat (15) @(posedge clk_rom); #1;
    check("t5_no_pref", 32'(ioctl_addr), 32'h143);
    check("t5_uploading_after", 32'(uploading), 32'h0);
    ds_done = 1'b0;
    @(posedge clk_rom); #1;

    // 6: reset during byte 2 of a fetch
    issue(32'hF800_0060, rc);
    repeat (4) @(posedge clk_rom); #1;
    check("t6_byte2_addr", 32'(ioctl_addr), 32'h182);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("t6_rst_data", rd_data, 32'h0);
    check("t6_rst_addr", 32'(ioctl_addr), 32'h0);
    check("t6_rst_flags", 32'({rd_ack, ioctl_ram, uploading, req_ovf}), 32'h0);
    repeat (2) @(posedge clk_rom); #1;
    rst = 1'b0;
    repeat (15) @(posedge clk_rom); #1;
    check("t6_no_ack", 32'(ack_cnt), 32'(na));
    issue(32'h2000_0000, rc); na++;
    wait_ack(na, 5, "t6_oow_ack");
    check("t6_oow_ram", 32'({ioctl_ram, uploading}), 32'h0);
    issue(32'hF800_0060, rc); na++;
    wait_ack(na, 20, "t6_ack");
    check("t6_latency", 32'(ack_cyc - rc), 32'd10);
    check("t6_data", rd_data, 32'h2627_2425);
    check("t6_uploading", 32'(uploading), 32'h1);
    repeat (15) @(posedge clk_rom);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
